// File: rtl/io_bank_pkg.sv
// io_bank_pkg
//   Shared command encodings for the GPIO bank. pkt_decode imports the same
//   package, so both sides always agree on the opcode values.
//   Contents: opcode width, opcode localparams, command type, and is_read().
package io_bank_pkg;

  localparam int OP_NBIT = 3;

  typedef logic [OP_NBIT-1:0] op_t;

  localparam op_t OP_WR_DIR  = 3'd0;
  localparam op_t OP_WR_DATA = 3'd1;
  localparam op_t OP_SET     = 3'd2;
  localparam op_t OP_CLR     = 3'd3;
  localparam op_t OP_TGL     = 3'd4;
  localparam op_t OP_RD_PIN  = 3'd5;
  localparam op_t OP_RD_CHG  = 3'd6;
  localparam op_t OP_RD_OUT  = 3'd7;

  // True for the opcodes that return one response word.
  function automatic logic is_read(input op_t op);
    return (op == OP_RD_PIN) || (op == OP_RD_CHG) || (op == OP_RD_OUT);
  endfunction

endpackage

// File: rtl/io_bank_if.sv
// io_bank_if
//   Command/response bus between pkt_decode (master) and io_bank (slave).
//   master: drives cmd_vd/cmd_op/cmd_port/cmd_data, receives rsp_vd/rsp_data.
//   slave : receives the command fields, drives the response.
interface io_bank_if
  import io_bank_pkg::*;
#(
  parameter int NPORT = 3,
  parameter int NBIT  = 8
) ();

  localparam int PORT_NBIT = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic                 cmd_vd;
  op_t                  cmd_op;
  logic [PORT_NBIT-1:0] cmd_port;
  logic [NBIT-1:0]      cmd_data;
  logic                 rsp_vd;
  logic [NBIT-1:0]      rsp_data;

  modport master (
    output cmd_vd, cmd_op, cmd_port, cmd_data,
    input  rsp_vd, rsp_data
  );

  modport slave (
    input  cmd_vd, cmd_op, cmd_port, cmd_data,
    output rsp_vd, rsp_data
  );

endinterface

// File: rtl/io_bank_sync.sv
// io_sync
//   One GPIO port's input path: 2-flop synchroniser, previous-value register
//   and a sticky change latch.
//   clk, rst  : clock, synchronous active-high reset
//   pin_in    : raw asynchronous pad input
//   clr       : clear the change latch (a same-cycle new change still sets)
//   sync_out  : synchronised pin value (pad + 2 cycles)
//   chg_out   : sticky per-bit change latch (pad + 3 cycles)
module io_sync #(
  parameter int NBIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBIT-1:0] pin_in,
  input  logic            clr,
  output logic [NBIT-1:0] sync_out,
  output logic [NBIT-1:0] chg_out
);

  logic [NBIT-1:0] meta_q;
  logic [NBIT-1:0] sync_q;
  logic [NBIT-1:0] prev_q;
  logic [NBIT-1:0] chg_q;

  // The set term is OR-ed after the clear so a change in the clear cycle
  // is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      chg_q  <= '0;
    end else begin
      meta_q <= pin_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      chg_q  <= (clr ? '0 : chg_q) | (sync_q ^ prev_q);
    end
  end

  assign sync_out = sync_q;
  assign chg_out  = chg_q;

endmodule

// File: rtl/io_bank.sv
// io_bank
//   Parametrised bank of bidirectional GPIO ports with a registered
//   command/response bus and a programmable test-point divider.
//   clk, rst : clock, synchronous active-high reset
//   bus      : command/response bus (slave side)
//   io_dir   : per-pin output enable, port p at [p*NBIT +: NBIT]
//   io_do    : per-pin output value (always reflects the out register)
//   io_di    : raw asynchronous pad inputs
//   chg_flag : per-port OR of the change latch
//   tp_en    : test-point enable (0 clears counter and tp_out)
//   tp_div   : half-period minus one, sampled at each wrap
//   tp_out   : test-point square wave
module io_bank
  import io_bank_pkg::*;
#(
  parameter int NPORT    = 3,
  parameter int NBIT     = 8,
  parameter int DIV_NBIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  io_bank_if.slave              bus,
  output logic [NPORT*NBIT-1:0] io_dir,
  output logic [NPORT*NBIT-1:0] io_do,
  input  logic [NPORT*NBIT-1:0] io_di,
  output logic [NPORT-1:0]      chg_flag,
  input  logic                  tp_en,
  input  logic [DIV_NBIT-1:0]   tp_div,
  output logic                  tp_out
);

  localparam int PORT_NBIT = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic                 cmd_vd;
  op_t                  cmd_op;
  logic [PORT_NBIT-1:0] cmd_port;
  logic [NBIT-1:0]      cmd_data;

  assign cmd_vd   = bus.cmd_vd;
  assign cmd_op   = bus.cmd_op;
  assign cmd_port = bus.cmd_port;
  assign cmd_data = bus.cmd_data;

  logic [NPORT-1:0][NBIT-1:0] dir_q;
  logic [NPORT-1:0][NBIT-1:0] out_q;
  logic [NPORT-1:0][NBIT-1:0] sync_val;
  logic [NPORT-1:0][NBIT-1:0] chg_val;
  logic [NPORT-1:0]           port_sel;
  logic [NPORT-1:0]           chg_clr;

  // An out-of-range cmd_port selects no port, so writes fall through and
  // reads return the zero default of the read mux.
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign port_sel[p] = cmd_vd && (cmd_port == PORT_NBIT'(p));
    assign chg_clr[p]  = port_sel[p] && (cmd_op == OP_RD_CHG);
    assign chg_flag[p] = |chg_val[p];

    io_sync #(.NBIT(NBIT)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .pin_in   (io_di[p*NBIT +: NBIT]),
      .clr      (chg_clr[p]),
      .sync_out (sync_val[p]),
      .chg_out  (chg_val[p])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= '0;
      out_q <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (port_sel[p]) begin
          case (cmd_op)
            OP_WR_DIR:  dir_q[p] <= cmd_data;
            OP_WR_DATA: out_q[p] <= cmd_data;
            OP_SET:     out_q[p] <= out_q[p] | cmd_data;
            OP_CLR:     out_q[p] <= out_q[p] & ~cmd_data;
            OP_TGL:     out_q[p] <= out_q[p] ^ cmd_data;
            default:    ;
          endcase
        end
      end
    end
  end

  assign io_dir = dir_q;
  assign io_do  = out_q;

  logic [NBIT-1:0] rd_val;

  // RD_CHG returns the latch value before this cycle's clear takes effect.
  always_comb begin
    rd_val = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (port_sel[p]) begin
        case (cmd_op)
          OP_RD_PIN: rd_val = sync_val[p];
          OP_RD_CHG: rd_val = chg_val[p];
          OP_RD_OUT: rd_val = out_q[p];
          default:   rd_val = '0;
        endcase
      end
    end
  end

  logic            rsp_vd_q;
  logic [NBIT-1:0] rsp_data_q;

  // rsp_data is only loaded on a read, so it holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vd_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      rsp_vd_q <= cmd_vd && is_read(cmd_op);
      if (cmd_vd && is_read(cmd_op)) begin
        rsp_data_q <= rd_val;
      end
    end
  end

  assign bus.rsp_vd   = rsp_vd_q;
  assign bus.rsp_data = rsp_data_q;

  logic [DIV_NBIT-1:0] tp_cnt;
  logic [DIV_NBIT-1:0] tp_lim;
  logic                tp_q;

  // tp_lim is the divider value in force for the current half-period; it is
  // reloaded only at wrap (and continuously while disabled, so an enable
  // starts with the value presented beforehand).
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_cnt <= '0;
      tp_lim <= '0;
      tp_q   <= 1'b0;
    end else if (!tp_en) begin
      tp_cnt <= '0;
      tp_lim <= tp_div;
      tp_q   <= 1'b0;
    end else if (tp_cnt == tp_lim) begin
      tp_cnt <= '0;
      tp_lim <= tp_div;
      tp_q   <= ~tp_q;
    end else begin
      tp_cnt <= tp_cnt + DIV_NBIT'(1);
    end
  end

  assign tp_out = tp_q;

endmodule

// File: tb/tb_io_bank.sv
// tb_io_bank
//   Randomised and directed stimulus for io_bank. Read responses are
//   predicted into a scoreboard queue and checked by an independent monitor;
//   register outputs and the test point are checked from the stimulus side.
module tb_io_bank;
  import io_bank_pkg::*;

  localparam int NPORT    = 3;
  localparam int NBIT     = 8;
  localparam int DIV_NBIT = 16;
  localparam int W        = NPORT * NBIT;
  localparam int PW       = $clog2(NPORT);

  logic                clk = 1'b0;
  logic                rst;
  logic [W-1:0]        io_dir;
  logic [W-1:0]        io_do;
  logic [W-1:0]        io_di;
  logic [NPORT-1:0]    chg_flag;
  logic                tp_en;
  logic [DIV_NBIT-1:0] tp_div;
  logic                tp_out;

  always #5 clk = ~clk;

  io_bank_if #(.NPORT(NPORT), .NBIT(NBIT)) bus ();

  io_bank #(.NPORT(NPORT), .NBIT(NBIT), .DIV_NBIT(DIV_NBIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .io_dir   (io_dir),
    .io_do    (io_do),
    .io_di    (io_di),
    .chg_flag (chg_flag),
    .tp_en    (tp_en),
    .tp_div   (tp_div),
    .tp_out   (tp_out)
  );

  // Reference model: register contents, the pad history (sync is the pad
  // two cycles ago) and the sticky change bits per port.
  logic [NBIT-1:0] dir_m [NPORT];
  logic [NBIT-1:0] out_m [NPORT];
  logic [NBIT-1:0] chg_m [NPORT];
  logic [W-1:0]    hist [$];

  typedef struct {
    logic [NBIT-1:0] data;
    int              due;
  } exp_t;
  exp_t sb [$];

  int              cycle = 0;
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [NBIT-1:0] last_rsp;
  logic [W-1:0]    cur_pad;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < NPORT; p++) begin
      dir_m[p] = '0;
      out_m[p] = '0;
      chg_m[p] = '0;
    end
    hist.delete();
    repeat (4) hist.push_back('0);
    last_rsp = '0;
  endtask

  // One clock cycle: check register outputs against the model, drive the
  // command and pads, predict any response, then advance the model.
  task automatic applyStimulus(input logic vd, input op_t op, input int port,
                               input logic [NBIT-1:0] data, input logic [W-1:0] pad);
    logic [W-1:0]     exp_dir;
    logic [W-1:0]     exp_do;
    logic [NPORT-1:0] exp_flag;
    logic [W-1:0]     s2;
    logic [W-1:0]     s3;
    logic [W-1:0]     diff;
    logic [NBIT-1:0]  rd;
    exp_t             e;
    @(posedge clk);
    #1;
    for (int p = 0; p < NPORT; p++) begin
      exp_dir[p*NBIT +: NBIT] = dir_m[p];
      exp_do[p*NBIT +: NBIT]  = out_m[p];
      exp_flag[p]             = |chg_m[p];
    end
    checkOutput("io_dir", io_dir, exp_dir);
    checkOutput("io_do", io_do, exp_do);
    checkOutput("chg_flag", W'(chg_flag), W'(exp_flag));

    bus.cmd_vd   = vd;
    bus.cmd_op   = op;
    bus.cmd_port = PW'(port);
    bus.cmd_data = data;
    io_di        = pad;
    hist.push_front(pad);
    if (hist.size() > 4) void'(hist.pop_back());
    s2 = hist[2];
    s3 = hist[3];

    if (vd && is_read(op)) begin
      rd = '0;
      if (port < NPORT) begin
        if (op == OP_RD_PIN) rd = s2[port*NBIT +: NBIT];
        if (op == OP_RD_CHG) rd = chg_m[port];
        if (op == OP_RD_OUT) rd = out_m[port];
      end
      e.data = rd;
      e.due  = cycle + 1;
      sb.push_back(e);
    end

    if (vd && port < NPORT) begin
      case (op)
        OP_WR_DIR:  dir_m[port] = data;
        OP_WR_DATA: out_m[port] = data;
        OP_SET:     out_m[port] = out_m[port] | data;
        OP_CLR:     out_m[port] = out_m[port] & ~data;
        OP_TGL:     out_m[port] = out_m[port] ^ data;
        default:    ;
      endcase
    end

    diff = s2 ^ s3;
    for (int p = 0; p < NPORT; p++) begin
      chg_m[p] = ((vd && op == OP_RD_CHG && port == p) ? '0 : chg_m[p]) | diff[p*NBIT +: NBIT];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, OP_WR_DIR, 0, '0, cur_pad);
  endtask

  // Count cycles until tp_out changes; optionally load a new divider after
  // chg_at cycles of this half-period.
  task automatic tpWait(input string name, input int exp, input int chg_at,
                        input logic [DIV_NBIT-1:0] new_div);
    logic prev;
    int   n;
    prev = tp_out;
    n    = 0;
    while (tp_out === prev && n < 200) begin
      idle(1);
      n++;
      if (n == chg_at) tp_div = new_div;
    end
    checkOutput(name, W'(n), W'(exp));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_vd === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL rsp_unexpected: got rsp_vd=1 data %h expected no response (cycle %0d)",
                 bus.rsp_data, cycle);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_data", W'(bus.rsp_data), W'(e.data));
        checkOutput("rsp_cycle", W'(cycle), W'(e.due));
        last_rsp = e.data;
      end
    end else if (rst === 1'b0) begin
      checkOutput("rsp_hold", W'(bus.rsp_data), W'(last_rsp));
    end
  end

  task automatic doReset(input logic vd, input op_t op, input int port, input logic [NBIT-1:0] data);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.cmd_vd   = vd;
    bus.cmd_op   = op;
    bus.cmd_port = PW'(port);
    bus.cmd_data = data;
    cur_pad      = '0;
    io_di        = '0;
    tp_en        = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_vd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    rst          = 1'b1;
    bus.cmd_vd   = 1'b0;
    bus.cmd_op   = OP_WR_DIR;
    bus.cmd_port = '0;
    bus.cmd_data = '0;
    io_di        = '0;
    cur_pad      = '0;
    tp_en        = 1'b0;
    tp_div       = 16'd24;
    modelReset();
    doReset(1'b0, OP_WR_DIR, 0, '0);
    idle(1);
    checkOutput("reset_tp_out", W'(tp_out), '0);

    // Direction and data on port 1, then read back.
    applyStimulus(1'b1, OP_WR_DIR, 1, 8'hFF, cur_pad);
    applyStimulus(1'b1, OP_WR_DATA, 1, 8'hA5, cur_pad);
    applyStimulus(1'b1, OP_RD_OUT, 1, 8'h00, cur_pad);
    idle(1);
    checkOutput("p1_dir", W'(io_dir[15:8]), W'(8'hFF));
    checkOutput("p1_do", W'(io_do[15:8]), W'(8'hA5));

    // Set/clear/toggle on port 0.
    applyStimulus(1'b1, OP_WR_DATA, 0, 8'hF0, cur_pad);
    applyStimulus(1'b1, OP_SET, 0, 8'h0F, cur_pad);
    applyStimulus(1'b1, OP_CLR, 0, 8'h81, cur_pad);
    applyStimulus(1'b1, OP_TGL, 0, 8'hFF, cur_pad);
    applyStimulus(1'b1, OP_RD_OUT, 0, 8'h00, cur_pad);
    idle(1);
    checkOutput("p0_do", W'(io_do[7:0]), W'(8'h81));

    // Pad change on port 2, sampled through the synchroniser.
    cur_pad = 24'h3C0000;
    idle(2);
    applyStimulus(1'b1, OP_RD_PIN, 2, 8'h00, cur_pad);
    idle(1);
    checkOutput("chg_flag2_set", W'(chg_flag[2]), W'(1'b1));
    applyStimulus(1'b1, OP_RD_CHG, 2, 8'h00, cur_pad);
    idle(1);
    checkOutput("chg_flag2_clr", W'(chg_flag[2]), W'(1'b0));

    // Pad edge reaching the change latch in the same cycle as the clear.
    cur_pad = 24'hC30000;
    idle(2);
    applyStimulus(1'b1, OP_RD_CHG, 2, 8'h00, cur_pad);
    idle(1);
    checkOutput("chg_flag2_setwins", W'(chg_flag[2]), W'(1'b1));
    applyStimulus(1'b1, OP_RD_CHG, 2, 8'h00, cur_pad);

    // Out-of-range port: write ignored, read answers zero.
    applyStimulus(1'b1, OP_WR_DATA, 3, 8'h55, cur_pad);
    applyStimulus(1'b1, OP_RD_PIN, 3, 8'h00, cur_pad);
    idle(2);

    // Test point at 24, then 4 loaded mid-period.
    tp_div = 16'd24;
    tp_en  = 1'b1;
    tpWait("tp_first_half", 25, 0, '0);
    tpWait("tp_half_24", 25, 10, 16'd4);
    tpWait("tp_half_4a", 5, 0, '0);
    tpWait("tp_half_4b", 5, 0, '0);
    tpWait("tp_half_4c", 5, 0, '0);
    checkOutput("tp_high_before_off", W'(tp_out), W'(1'b1));
    tp_en = 1'b0;
    idle(1);
    checkOutput("tp_off", W'(tp_out), '0);

    // Divider of zero toggles every cycle.
    tp_div = 16'd0;
    idle(1);
    tp_en = 1'b1;
    tpWait("tp_div0_a", 1, 0, '0);
    tpWait("tp_div0_b", 1, 0, '0);
    tpWait("tp_div0_c", 1, 0, '0);
    tp_en = 1'b0;
    idle(1);

    // Random command and pad traffic.
    for (int i = 0; i < 600; i++) begin
      logic            vd;
      op_t             op;
      int              port;
      logic [NBIT-1:0] data;
      vd   = ($urandom_range(0, 3) != 0);
      op   = op_t'($urandom_range(0, 7));
      port = $urandom_range(0, 3);
      data = NBIT'($urandom);
      if ($urandom_range(0, 3) == 0) cur_pad = W'($urandom);
      applyStimulus(vd, op, port, data, cur_pad);
    end
    idle(3);

    // Reset in the middle of a read and a write: no response, nothing kept.
    applyStimulus(1'b1, OP_WR_DATA, 0, 8'h3A, cur_pad);
    idle(1);
    doReset(1'b1, OP_RD_OUT, 0, 8'h00);
    doReset(1'b1, OP_WR_DATA, 1, 8'h77);
    idle(3);
    checkOutput("post_reset_do", io_do, '0);
    checkOutput("post_reset_dir", io_dir, '0);
    checkOutput("sb_drained", W'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
